// File: rtl/simple_sequencer.sv
// simple_sequencer: fetch/operand/execute/memory control FSM for the learning 6502 core
module simple_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  input  logic [7:0]       mem_rdata,
  input  logic             mem_ready,
  input  logic             is_load,
  input  logic             is_store,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             pc_inc,
  output logic [7:0]       ir,
  output logic [7:0]       opl,
  output logic [7:0]       oph,
  output logic             exec_strobe,
  output logic             data_load,
  output logic             retire,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [2:0] {
    FETCH = 3'd0, OPL = 3'd1, OPH = 3'd2, EXEC = 3'd3, MEMRD = 3'd4, MEMWR = 3'd5
  } state_t;
  state_t st;
  logic pend, req, done, imm, mem_op;
  logic [1:0] op_len, len;
  always_comb begin
    len = (mem_rdata[3:2] == 2'b11 || mem_rdata == 8'h20 || (mem_rdata[3:0] == 4'h9 && mem_rdata[4])) ? 2'd2 :
          (mem_rdata[3:0] == 4'h8 || mem_rdata[3:0] == 4'hA || mem_rdata == 8'h00 ||
           mem_rdata == 8'h40 || mem_rdata == 8'h60) ? 2'd0 : 2'd1;
    imm = (ir[3:0] == 4'h9 && !ir[4]) || ir == 8'hA0 || ir == 8'hA2;
    mem_op = is_store || (is_load && !imm);
    // pend keeps a fetch request alive once issued, even if halt rises
    req = !rst && ((st == FETCH && (!halt || pend)) || st == OPL || st == OPH || st == MEMRD || st == MEMWR);
    done = req && mem_ready;
    mem_req = req;
    mem_we = !rst && st == MEMWR;
    addr_sel = !rst && (st == MEMRD || st == MEMWR);
    pc_inc = done && (st == FETCH || st == OPL || st == OPH);
    exec_strobe = !rst && st == EXEC;
    data_load = done && st == MEMRD;
    retire = (exec_strobe && !mem_op) || (done && (st == MEMRD || st == MEMWR));
  end
  assign state = st;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= FETCH;
      ir <= 8'hEA;
      opl <= '0;
      oph <= '0;
      op_len <= '0;
      pend <= 1'b0;
      instr_count <= '0;
    end else begin
      pend <= st == FETCH && req && !mem_ready;
      if (retire) instr_count <= instr_count + CNT_W'(1);
      case (st)
        FETCH: if (done) begin
          ir <= mem_rdata;
          op_len <= len;
          st <= (len == 2'd0) ? EXEC : OPL;
        end
        OPL: if (done) begin
          opl <= mem_rdata;
          st <= (op_len == 2'd2) ? OPH : EXEC;
        end
        OPH: if (done) begin
          oph <= mem_rdata;
          st <= EXEC;
        end
        EXEC: st <= is_store ? MEMWR : mem_op ? MEMRD : FETCH;
        MEMRD, MEMWR: if (done) st <= FETCH;
        default: st <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_simple_sequencer.sv
// tb_simple_sequencer: phase-level model of instruction traffic, checked every cycle
module tb_simple_sequencer;
  logic clk = 0, rst = 1, halt = 1, mem_ready = 0, is_load = 0, is_store = 0;
  logic [7:0] mem_rdata = 0;
  logic mem_req, mem_we, addr_sel, pc_inc, exec_strobe, data_load, retire;
  logic [7:0] ir, opl, oph;
  logic [2:0] state;
  logic [3:0] instr_count;
  simple_sequencer #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .halt(halt), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .is_load(is_load), .is_store(is_store), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .pc_inc(pc_inc), .ir(ir), .opl(opl), .oph(oph),
    .exec_strobe(exec_strobe), .data_load(data_load), .retire(retire),
    .state(state), .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rst, halt, rdy, ld, sto;
    logic [7:0] rd;
    logic [2:0] st;
    logic req, we, asel, pci, ex, dl, ret;
    int upd;
  } ent_t;
  ent_t q[$];
  int tests = 0, fails = 0;
  int ncyc, npci, ndl, nret;
  logic [7:0] m_ir = 8'hEA, m_opl = 0, m_oph = 0;
  logic [3:0] m_cnt = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int len_of(input logic [7:0] o);
    if (o[3:2] == 2'b11 || o == 8'h20 || (o[3:0] == 4'h9 && o[4])) return 2;
    if (o[3:0] == 4'h8 || o[3:0] == 4'hA || o == 8'h00 || o == 8'h40 || o == 8'h60) return 0;
    return 1;
  endfunction
  function automatic bit is_imm(input logic [7:0] o);
    return (o[3:0] == 4'h9 && !o[4]) || o == 8'hA0 || o == 8'hA2;
  endfunction
  task automatic put(input logic [2:0] s, input bit h, input bit rdy, input logic [7:0] rd,
                     input int upd, input bit ld, input bit sto, input bit rq);
    ent_t e;
    bit d = rq && rdy;
    e = '{rst: 0, halt: h, rdy: rdy, ld: ld, sto: sto, rd: rd, st: s, req: rq,
          we: s == 5, asel: s >= 4, pci: d && s <= 2, ex: 0, dl: d && s == 4,
          ret: d && s >= 4, upd: d ? upd : 0};
    q.push_back(e);
  endtask
  // a memory phase: some wait cycles, then the completing cycle
  task automatic ph(input logic [2:0] s, input bit h, input int w, input logic [7:0] rd,
                    input int upd, input bit ld, input bit sto);
    for (int i = 0; i < w; i++) put(s, h, 0, 8'hFF, 0, ld, sto, 1);
    put(s, h, 1, rd, upd, ld, sto, 1);
  endtask
  task automatic idle();
    put(0, 1, 1, 8'h11, 0, 0, 0, 0);
  endtask
  task automatic instr(input logic [7:0] op, input logic [7:0] b1, input logic [7:0] b2,
                       input bit ld, input bit sto, input int w);
    ent_t e;
    int n = len_of(op);
    bit mem = sto || (ld && !is_imm(op));
    ph(0, 0, w, op, 1, ld, sto);
    if (n >= 1) ph(1, 0, w, b1, 2, ld, sto);
    if (n == 2) ph(2, 0, w, b2, 3, ld, sto);
    e = '{rst: 0, halt: 0, rdy: 1, ld: ld, sto: sto, rd: 8'h77, st: 3, req: 0, we: 0,
          asel: 0, pci: 0, ex: 1, dl: 0, ret: !mem, upd: 0};
    q.push_back(e);
    if (mem) ph(sto ? 3'd5 : 3'd4, 0, w, 8'h5A, 0, ld, sto);
  endtask
  task automatic run();
    ent_t e;
    ncyc = 0; npci = 0; ndl = 0; nret = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(posedge clk); #1;
      rst = e.rst; halt = e.halt; mem_ready = e.rdy; mem_rdata = e.rd;
      is_load = e.ld; is_store = e.sto;
      @(negedge clk);
      chk("state", state, e.st);
      chk("mem_req", mem_req, e.req);
      chk("mem_we", mem_we, e.we);
      chk("addr_sel", addr_sel, e.asel);
      chk("pc_inc", pc_inc, e.pci);
      chk("exec_strobe", exec_strobe, e.ex);
      chk("data_load", data_load, e.dl);
      chk("retire", retire, e.ret);
      chk("ir", ir, m_ir);
      chk("opl", opl, m_opl);
      chk("oph", oph, m_oph);
      chk("instr_count", instr_count, m_cnt);
      if (mem_req || state != 0) ncyc++;
      npci += int'(pc_inc); ndl += int'(data_load); nret += int'(retire);
      case (e.upd)
        1: m_ir = e.rd;
        2: m_opl = e.rd;
        3: m_oph = e.rd;
        4: begin m_ir = 8'hEA; m_opl = 0; m_oph = 0; m_cnt = 0; end
        default: ;
      endcase
      if (e.ret) m_cnt++;
    end
  endtask
  initial begin
    ent_t r;
    chk("len EA", len_of(8'hEA), 0);
    chk("len A9", len_of(8'hA9), 1);
    chk("len 8D", len_of(8'h8D), 2);
    chk("len 20", len_of(8'h20), 2);
    chk("len B9", len_of(8'hB9), 2);
    chk("len 60", len_of(8'h60), 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst state", state, 0);
    chk("rst ir", ir, 8'hEA);
    chk("rst opl", opl, 0);
    chk("rst oph", oph, 0);
    chk("rst count", instr_count, 0);
    chk("rst mem_req", mem_req, 0);
    instr(8'hEA, 0, 0, 0, 0, 0); idle(); run();
    chk("nop cycles", ncyc, 2);
    chk("nop pc_inc", npci, 1);
    chk("nop retire", nret, 1);
    chk("nop count", instr_count, 1);
    instr(8'hA9, 8'h42, 0, 1, 0, 0); idle(); run();
    chk("ldi cycles", ncyc, 3);
    chk("ldi pc_inc", npci, 2);
    chk("ldi data_load", ndl, 0);
    chk("ldi ir", ir, 8'hA9);
    chk("ldi opl", opl, 8'h42);
    instr(8'h8D, 8'h00, 8'h02, 0, 1, 0); idle(); run();
    chk("sta cycles", ncyc, 5);
    chk("sta addr", {oph, opl}, 16'h0200);
    chk("sta retire", nret, 1);
    instr(8'hAD, 8'h34, 8'h12, 1, 0, 3); idle(); run();
    chk("lda wait cycles", ncyc, 17);
    chk("lda data_load", ndl, 1);
    chk("lda count", instr_count, 4);
    chk("lda addr", {oph, opl}, 16'h1234);
    for (int i = 0; i < 10; i++) idle();
    run();
    chk("halt cycles", ncyc, 0);
    put(0, 0, 0, 8'hFF, 0, 1, 0, 1);
    ph(0, 1, 1, 8'hA5, 1, 1, 0);
    ph(1, 1, 0, 8'h80, 2, 1, 0);
    put(3, 1, 0, 8'h00, 0, 1, 0, 0);
    q[q.size()-1].ex = 1;
    ph(4, 1, 0, 8'h99, 0, 1, 0);
    idle(); run();
    chk("halt-held ir", ir, 8'hA5);
    chk("halt-held data_load", ndl, 1);
    chk("halt-held count", instr_count, 5);
    ph(0, 0, 0, 8'hAD, 1, 1, 0);
    ph(1, 0, 0, 8'h34, 2, 1, 0);
    put(2, 0, 0, 8'hFF, 0, 1, 0, 1);
    put(2, 0, 0, 8'hFF, 0, 1, 0, 1);
    r = '{rst: 1, halt: 0, rdy: 1, ld: 1, sto: 0, rd: 8'h56, st: 2, req: 0, we: 0,
          asel: 0, pci: 0, ex: 0, dl: 0, ret: 0, upd: 4};
    q.push_back(r);
    idle(); run();
    chk("mid-rst state", state, 0);
    chk("mid-rst ir", ir, 8'hEA);
    chk("mid-rst count", instr_count, 0);
    chk("mid-rst retire", nret, 0);
    for (int i = 0; i < 17; i++) instr(8'hEA, 0, 0, 0, 0, 0);
    idle(); run();
    chk("wrap count", instr_count, 1);
    chk("wrap retires", nret, 17);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
